// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed common-anode 7-segment driver: scans NUM_DIGITS hex digits with
// per-digit enable, decimal point, leading-zero suppression and an anti-ghosting blank.
module seven_seg_mux_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_zeros,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      dp,
    output logic                      frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            lat_nib;
    logic                  lat_dp;
    logic                  lat_vis;

    logic [NUM_DIGITS-1:0] supp;
    logic                  higher_zero;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_vis;
    logic                  slot_start;
    logic [3:0]            slot_nib;
    logic                  slot_dp;
    logic                  slot_vis;
    logic                  in_blank;
    logic [NUM_DIGITS-1:0] onehot;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Walk from the most significant digit down; a digit is suppressed only while every
    // enabled digit above it is zero. Disabled digits never break the run of zeros.
    always_comb begin
        supp        = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            supp[i] = blank_zeros && (i != 0) && (digits[4*i +: 4] == 4'h0) && higher_zero;
            if (digit_en[i] && (digits[4*i +: 4] != 4'h0)) begin
                higher_zero = 1'b0;
            end
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_vis = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nib = digits[4*i +: 4];
                cur_dp  = dp_in[i];
                cur_vis = digit_en[i] && !supp[i];
            end
        end
    end

    // The slot-start cycle uses the live inputs directly so the outputs of slot cycle 0
    // already show the new digit; the rest of the slot uses the latched copy.
    assign slot_start = (cnt == '0);
    assign slot_nib   = slot_start ? cur_nib : lat_nib;
    assign slot_dp    = slot_start ? cur_dp  : lat_dp;
    assign slot_vis   = slot_start ? cur_vis : lat_vis;
    assign in_blank   = ({{(32-CNT_W){1'b0}}, cnt} < 32'(BLANK_CYCLES));
    assign onehot     = NUM_DIGITS'(1) << idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            lat_nib    <= 4'h0;
            lat_dp     <= 1'b0;
            lat_vis    <= 1'b0;
            seg        <= 7'h7F;
            an         <= '1;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (slot_start) begin
                lat_nib <= cur_nib;
                lat_dp  <= cur_dp;
                lat_vis <= cur_vis;
            end
            seg        <= slot_vis ? hex_to_seg(slot_nib) : 7'h7F;
            dp         <= slot_vis ? ~slot_dp : 1'b1;
            an         <= (in_blank || !slot_vis) ? '1 : ~onehot;
            frame_tick <= slot_start && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Directed bench for seven_seg_mux_driver with 4 digits, 8-cycle slots and 2 blank cycles.
module tb_seven_seg_mux_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;

    logic          clk;
    logic          rst;
    logic [15:0]   digits;
    logic [3:0]    digit_en;
    logic [3:0]    dp_in;
    logic          blank_zeros;
    logic [6:0]    seg;
    logic [3:0]    an;
    logic          dp;
    logic          frame_tick;

    int tests_run = 0;
    int fail_cnt  = 0;

    seven_seg_mux_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .digit_en   (digit_en),
        .dp_in      (dp_in),
        .blank_zeros(blank_zeros),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]        digits;
        logic [3:0]         en;
        logic [3:0]         dpi;
        logic               bz;
        logic [3:0][6:0]    seg;     // expected seg per slot, [3] = digit 3
        logic [3:0]         lit;     // digits whose anode lights after the blank
        logic [3:0]         dp_out;  // expected dp pin per slot
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // advance one cycle and land on the falling edge to sample outputs
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dp", 32'(dp), 32'h1);
        chk("reset_ft", 32'(frame_tick), 32'h0);
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        digits      = v.digits;
        digit_en    = v.en;
        dp_in       = v.dpi;
        blank_zeros = v.bz;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int s;
        int c;
        logic [3:0] exp_an;
        apply(v);
        do_reset();
        for (int k = 0; k < 2 * ND * RD; k++) begin
            step();
            s = (k / RD) % ND;
            c = k % RD;
            exp_an = (c < BC || !v.lit[s]) ? 4'hF : ~(4'b0001 << s);
            chk($sformatf("v%0d_k%0d_an", n, k), 32'(an), 32'(exp_an));
            chk($sformatf("v%0d_k%0d_seg", n, k), 32'(seg), 32'(v.seg[s]));
            chk($sformatf("v%0d_k%0d_dp", n, k), 32'(dp), 32'(v.dp_out[s]));
            chk($sformatf("v%0d_k%0d_ft", n, k), 32'(frame_tick), 32'(k % (ND * RD) == 0));
        end
    endtask

    initial begin
        rst         = 1'b1;
        digits      = 16'h0;
        digit_en    = 4'h0;
        dp_in       = 4'h0;
        blank_zeros = 1'b0;

        vecs[0] = '{16'h1234, 4'hF, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF};
        vecs[1] = '{16'h0050, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'h3, 4'hF};
        vecs[2] = '{16'h0050, 4'hF, 4'h0, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF, 4'hF};
        vecs[3] = '{16'hABCD, 4'h5, 4'h1, 1'b0, {7'h7F, 7'h03, 7'h7F, 7'h21}, 4'h5, 4'hE};
        vecs[4] = '{16'h0000, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'h1, 4'hF};
        vecs[5] = '{16'h5030, 4'h7, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 4'h3, 4'hF};
        vecs[6] = '{16'hE6F9, 4'hF, 4'hA, 1'b1, {7'h06, 7'h02, 7'h0E, 7'h10}, 4'hF, 4'h5};
        vecs[7] = '{16'h0C07, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h46, 7'h40, 7'h78}, 4'h7, 4'hF};

        for (int n = 0; n < 8; n++) begin
            run_vec(n, vecs[n]);
        end

        // Mid-slot input change: slot 0 keeps showing 8 until its next slot.
        digits      = 16'h0008;
        digit_en    = 4'hF;
        dp_in       = 4'h0;
        blank_zeros = 1'b0;
        do_reset();
        for (int k = 0; k <= 4; k++) step();
        chk("mid_seg_k4", 32'(seg), 32'h00);
        digits = 16'h000F;
        for (int k = 5; k < RD; k++) begin
            step();
            chk($sformatf("mid_seg_k%0d", k), 32'(seg), 32'h00);
        end
        for (int k = RD; k < ND * RD; k++) step();
        for (int k = ND * RD; k < ND * RD + RD; k++) begin
            step();
            chk($sformatf("mid_new_seg_k%0d", k), 32'(seg), 32'h0E);
        end
        chk("mid_new_ft_clear", 32'(frame_tick), 32'h0);

        // Reset in digit-2 slot cycle 5, then scanning restarts at digit 0.
        digits = 16'h1234;
        do_reset();
        for (int k = 0; k <= 2 * RD + 5; k++) step();
        chk("mr_pre_an", 32'(an), 32'hB);
        chk("mr_pre_seg", 32'(seg), 32'h24);
        rst = 1'b1;
        step();
        chk("mr_an", 32'(an), 32'hF);
        chk("mr_seg", 32'(seg), 32'h7F);
        chk("mr_dp", 32'(dp), 32'h1);
        chk("mr_ft", 32'(frame_tick), 32'h0);
        rst = 1'b0;
        step();
        chk("mr_restart_ft", 32'(frame_tick), 32'h1);
        chk("mr_restart_seg", 32'(seg), 32'h19);
        chk("mr_restart_an_blank", 32'(an), 32'hF);
        step();
        step();
        chk("mr_restart_an_lit", 32'(an), 32'hE);
        chk("mr_restart_ft_low", 32'(frame_tick), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
